uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 The block SHALL have parameter UART_DATA_WIDTH, default 8, giving the byte width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the completion watchdog limit in clk cycles.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic uses its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-006 The block SHALL have port req, input, NUM_REQ bits, one transmit request per requester.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*UART_DATA_WIDTH bits, holding requester i's byte in slice i.
REQ-008 The block SHALL have port gnt, output, NUM_REQ bits, the one-hot owner of the transmitter.
REQ-009 The block SHALL have port ack, output, NUM_REQ bits, a one-cycle per-requester completion pulse.
REQ-010 The block SHALL have port err, output, 1 bit, a one-cycle timeout pulse.
REQ-011 The block SHALL have port tx_data, output, UART_DATA_WIDTH bits, the byte presented to the UART transmitter.
REQ-012 The block SHALL have port tx_send, output, 1 bit, the one-cycle start strobe to the transmitter.
REQ-013 The block SHALL have port tx_busy, input, 1 bit, which is high while the transmitter is shifting.
REQ-014 The block SHALL have port tx_done, input, 1 bit, a one-cycle pulse when the stop bit completes.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, SEND and WAIT, and SHALL be held in IDLE during reset.
REQ-016 IDLE SHALL transition to SEND on a rising edge when req != 0 and tx_busy == 0, and SHALL stay in IDLE otherwise.
REQ-017 The winner SHALL be the first asserted req index at or above rr_ptr, searching ascending and wrapping from NUM_REQ-1 to 0.
REQ-018 On the IDLE->SEND edge, the block SHALL register the winner's req_data slice into tx_data and set gnt to the winner's one-hot code.
REQ-019 tx_data and gnt SHALL stay stable until the transfer returns to IDLE.
REQ-020 tx_send SHALL be high for exactly the single cycle spent in SEND, which is the cycle after the sampling edge.
REQ-021 SEND SHALL transition unconditionally to WAIT.
REQ-022 On a WAIT cycle with tx_done == 1, the block SHALL pulse ack[winner] for one cycle, set rr_ptr to (winner+1) mod NUM_REQ, clear gnt, and go to IDLE.
REQ-023 tx_done SHALL be ignored in IDLE and in SEND.
REQ-024 When a granted requester drops req mid-transfer, the transfer SHALL complete normally and ack SHALL still pulse.
REQ-025 The block SHALL spend at least one cycle in IDLE between transfers, so the minimum cycle from one tx_send to the next is the UART frame time plus 2 cycles.
REQ-026 At most one ack bit SHALL be high in any cycle, and ack and tx_send SHALL never be high in the same cycle.
REQ-027 A req asserted in the same cycle as the ack of another requester SHALL be arbitrated on the next IDLE cycle using the updated rr_ptr.

Reset
REQ-028 While rst == 1, the block SHALL force state=IDLE, rr_ptr=0, gnt=0, ack=0, err=0, tx_send=0, tx_data=0 and watchdog=0, without waiting for clk.
REQ-029 Asserting rst mid-transfer SHALL abandon the transfer with no ack; the first arbitration after release SHALL start from index 0.

Configuration
REQ-030 When UART_TX_ARB_TIMEOUT_EN is defined, a watchdog SHALL count the cycles spent in WAIT, clearing on entry to WAIT.
REQ-031 With UART_TX_ARB_TIMEOUT_EN defined, when the watchdog reaches TIMEOUT_CYCLES-1 with no tx_done, the block SHALL pulse err and ack[winner] together, advance rr_ptr and return to IDLE.
REQ-032 With UART_TX_ARB_TIMEOUT_EN defined, tx_done arriving in the same cycle as the timeout SHALL take priority, giving ack with err=0.
REQ-033 When UART_TX_ARB_TIMEOUT_EN is undefined, the block SHALL have no watchdog logic, SHALL tie err to 0, and WAIT SHALL exit only on tx_done.

Verification
REQ-034 The bench SHALL cover: after reset, req=4'b0100 with slice 2=8'hA5 -> tx_send one cycle after sampling with tx_data=8'hA5 and gnt=4'b0100; tx_done 10 cycles later -> ack=4'b0100 for one cycle.
REQ-035 The bench SHALL cover: req=4'b1111 held for four transfers -> grant order 0,1,2,3, then 0 again.
REQ-036 The bench SHALL cover: rr_ptr=3 with req=4'b0011 -> grant 0, next grant 1.
REQ-037 The bench SHALL cover: tx_busy=1 held for 5 cycles with req=4'b0001 -> no tx_send until the cycle after tx_busy falls.
REQ-038 The bench SHALL cover: macro defined, TIMEOUT_CYCLES=16, tx_done never asserted -> err and ack[winner] pulse 16 cycles after WAIT entry; macro undefined -> the block stays in WAIT and err remains 0.
REQ-039 The bench SHALL cover: rst pulsed in WAIT -> gnt=0 immediately with no ack; req=4'b1000 afterwards -> granted normally.

Source files
------------

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Round-robin arbiter sharing one UART transmitter between
//               NUM_REQ requesters. A three-state FSM (IDLE/SEND/WAIT)
//               captures the winner's byte, strobes tx_send for one cycle,
//               then waits for tx_done before acknowledging the winner and
//               moving the round-robin pointer past it.
//
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               req       - per-requester transmit request
//               req_data  - requester i's byte in slice i
//               gnt       - one-hot owner of the transmitter
//               ack       - one-cycle completion pulse to the owner
//               err       - one-cycle completion-timeout pulse
//               tx_data   - byte presented to the transmitter
//               tx_send   - one-cycle start strobe to the transmitter
//               tx_busy   - transmitter is shifting
//               tx_done   - transmitter finished the stop bit
//
// Options     : `define UART_TX_ARB_TIMEOUT_EN adds a WAIT-state watchdog
//               that forces completion (ack + err) after TIMEOUT_CYCLES.
//               Without it err is tied low and WAIT exits only on tx_done.
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
    parameter int NUM_REQ         = 4,
    parameter int UART_DATA_WIDTH = 8,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*UART_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                 gnt,
    output logic [NUM_REQ-1:0]                 ack,
    output logic                               err,
    output logic [UART_DATA_WIDTH-1:0]         tx_data,
    output logic                               tx_send,
    input  logic                               tx_busy,
    input  logic                               tx_done
);

    localparam int                   c_IDX_W = $clog2(NUM_REQ);
    localparam logic [c_IDX_W:0]     c_NUM   = (c_IDX_W+1)'(NUM_REQ);
    localparam logic [c_IDX_W-1:0]   c_LAST  = c_IDX_W'(NUM_REQ-1);
    localparam logic [NUM_REQ-1:0]   c_ONE   = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                     r_state;
    logic [c_IDX_W-1:0]         r_rr_ptr;
    logic [c_IDX_W-1:0]         r_winner;
    logic [NUM_REQ-1:0]         r_gnt;
    logic [NUM_REQ-1:0]         r_ack;
    logic [UART_DATA_WIDTH-1:0] r_data;
    logic                       r_send;

    logic [UART_DATA_WIDTH-1:0] w_slot [NUM_REQ];
    logic [c_IDX_W-1:0]         w_winner;
    logic [c_IDX_W:0]           w_sum;
    logic [c_IDX_W-1:0]         w_ptr_next;
    logic                       w_timeout;
    logic                       w_finish;

    // Unpack the flat request bus into per-requester bytes.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign w_slot[gi] = req_data[gi*UART_DATA_WIDTH +: UART_DATA_WIDTH];
        end
    endgenerate

    // Round-robin search: scan offsets from the highest down so the lowest
    // offset above rr_ptr (with wrap) is the last, and therefore winning, hit.
    always_comb begin
        w_winner = '0;
        w_sum    = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            if (req[w_sum[c_IDX_W-1:0]]) begin
                w_winner = w_sum[c_IDX_W-1:0];
            end
        end
    end

    assign w_ptr_next = (r_winner == c_LAST) ? '0 : r_winner + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int                 c_WD_W    = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES-1);

    logic [c_WD_W-1:0] r_wd;
    logic              r_err;

    assign w_timeout = (r_wd == c_WD_LAST);
    assign err       = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // tx_done wins over a simultaneous timeout because err is only raised
    // when tx_done is absent.
    assign w_finish = tx_done || w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_winner <= '0;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_data   <= '0;
            r_send   <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_wd     <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_ack  <= '0;
            r_send <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if ((|req) && !tx_busy) begin
                        r_state  <= S_SEND;
                        r_winner <= w_winner;
                        r_gnt    <= c_ONE << w_winner;
                        r_data   <= w_slot[w_winner];
                        r_send   <= 1'b1;
                    end
                end
                S_SEND: begin
                    r_state <= S_WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    r_wd    <= '0;
`endif
                end
                S_WAIT: begin
                    if (w_finish) begin
                        r_state  <= S_IDLE;
                        r_ack    <= r_gnt;
                        r_gnt    <= '0;
                        r_rr_ptr <= w_ptr_next;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        r_err    <= !tx_done;
`endif
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else begin
                        r_wd <= r_wd + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign ack     = r_ack;
    assign tx_data = r_data;
    assign tx_send = r_send;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arb
// Description : Self-checking bench for uart_tx_arb (4 requesters, 8-bit
//               bytes, TIMEOUT_CYCLES = 16). Expected grants and bytes are
//               queued when a request is driven and compared when tx_send
//               fires; completion, timeout and reset behaviour are checked
//               by hand-written sequences and a vector table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        err;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic        tx_done;

    int n_tests;
    int n_fail;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [3:0]  r;
        logic [31:0] d;
        int          dly;
        bit          hold;
        logic [3:0]  eg;
        logic [7:0]  ed;
    } vec_t;

    vec_t tbl[8];

    uart_tx_arb #(
        .NUM_REQ        (4),
        .UART_DATA_WIDTH(8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .gnt     (gnt),
        .ack     (ack),
        .err     (err),
        .tx_data (tx_data),
        .tx_send (tx_send),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every start strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_send) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected tx_send", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb gnt", {28'd0, gnt}, {28'd0, e.g});
                    chk("sb tx_data", {24'd0, tx_data}, {24'd0, e.d});
                end
            end
            if (ack != 4'd0) begin
                chk("ack onehot", {31'd0, $onehot(ack)}, 32'd1);
                chk("ack with tx_send", {31'd0, tx_send}, 32'd0);
            end
        end
    end

    task automatic finish_xfer(input int dly, input logic [3:0] eg, input logic [7:0] ed);
        repeat (dly) @(posedge clk);
        #1;
        chk("hold gnt", {28'd0, gnt}, {28'd0, eg});
        chk("hold tx_data", {24'd0, tx_data}, {24'd0, ed});
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        chk("ack pulse", {28'd0, ack}, {28'd0, eg});
        chk("gnt cleared", {28'd0, gnt}, 32'd0);
        chk("err on done", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        chk("ack one cycle", {28'd0, ack}, 32'd0);
    endtask

    task automatic wait_send();
        int n;
        n = 0;
        while (!tx_send && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send seen", {31'd0, tx_send}, 32'd1);
    endtask

    task automatic run_xfer(input logic [3:0] r, input logic [31:0] d, input int dly,
                            input bit hold, input logic [3:0] eg, input logic [7:0] ed);
        req      = r;
        req_data = d;
        sb_q.push_back('{g: eg, d: ed});
        wait_send();
        if (!hold) req = 4'd0;
        finish_xfer(dly, eg, ed);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst gnt", {28'd0, gnt}, 32'd0);
        chk("rst tx_send", {31'd0, tx_send}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = 4'd0;
        req_data = 32'd0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;

        //            req      slices 3..0     dly hold exp_gnt exp_byte
        tbl[0] = '{4'b1111, 32'h44332211, 10, 1'b1, 4'b0001, 8'h11};
        tbl[1] = '{4'b1111, 32'h44332211,  3, 1'b1, 4'b0010, 8'h22};
        tbl[2] = '{4'b1111, 32'h44332211,  1, 1'b1, 4'b0100, 8'h33};
        tbl[3] = '{4'b1111, 32'h44332211,  7, 1'b1, 4'b1000, 8'h44};
        tbl[4] = '{4'b1111, 32'h44332211,  2, 1'b0, 4'b0001, 8'h11};
        tbl[5] = '{4'b1001, 32'h9C00005E,  4, 1'b0, 4'b1000, 8'h9C};
        tbl[6] = '{4'b0110, 32'h00D2B100, 12, 1'b0, 4'b0010, 8'hB1};
        tbl[7] = '{4'b0011, 32'h00006A17,  5, 1'b0, 4'b0001, 8'h17};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset gnt", {28'd0, gnt}, 32'd0);
        chk("reset ack", {28'd0, ack}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset tx_send", {31'd0, tx_send}, 32'd0);
        chk("reset tx_data", {24'd0, tx_data}, 32'd0);
        rst = 1'b0;

        // Single request, exact latency; tx_done during SEND is ignored
        @(posedge clk); #1;
        req      = 4'b0100;
        req_data = 32'h00A50000;
        sb_q.push_back('{g: 4'b0100, d: 8'hA5});
        @(posedge clk); #1;
        chk("A send latency", {31'd0, tx_send}, 32'd1);
        chk("A tx_data", {24'd0, tx_data}, 32'h0000_00A5);
        chk("A gnt", {28'd0, gnt}, 32'h0000_0004);
        req     = 4'd0;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        chk("A done in SEND ignored", {28'd0, ack}, 32'd0);
        chk("A gnt in WAIT", {28'd0, gnt}, 32'h0000_0004);
        chk("A send one cycle", {31'd0, tx_send}, 32'd0);
        finish_xfer(9, 4'b0100, 8'hA5);

        // Pointer wrap: rr_ptr is 3 here
        run_xfer(4'b0011, 32'h0000BBAA, 4, 1'b0, 4'b0001, 8'hAA);
        run_xfer(4'b0011, 32'h0000BBAA, 4, 1'b0, 4'b0010, 8'hBB);

        // Transmitter busy holds off arbitration
        tx_busy  = 1'b1;
        req      = 4'b0001;
        req_data = 32'h0000005A;
        sb_q.push_back('{g: 4'b0001, d: 8'h5A});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("busy no send", {31'd0, tx_send}, 32'd0);
        end
        tx_busy = 1'b0;
        @(posedge clk); #1;
        chk("send after busy", {31'd0, tx_send}, 32'd1);
        req = 4'd0;
        finish_xfer(3, 4'b0001, 8'h5A);

        // Watchdog: no tx_done at all
        req      = 4'b0010;
        req_data = 32'h0000C300;
        sb_q.push_back('{g: 4'b0010, d: 8'hC3});
        wait_send();
        req = 4'd0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            chk("wd quiet err", {31'd0, err}, 32'd0);
            chk("wd quiet ack", {28'd0, ack}, 32'd0);
        end
        @(posedge clk); #1;
`ifdef UART_TX_ARB_TIMEOUT_EN
        chk("timeout err", {31'd0, err}, 32'd1);
        chk("timeout ack", {28'd0, ack}, 32'h0000_0002);
        chk("timeout gnt", {28'd0, gnt}, 32'd0);
        @(posedge clk); #1;
        chk("timeout err one cycle", {31'd0, err}, 32'd0);
        chk("timeout ack one cycle", {28'd0, ack}, 32'd0);
`else
        chk("no timeout err", {31'd0, err}, 32'd0);
        chk("still waiting gnt", {28'd0, gnt}, 32'h0000_0002);
        repeat (20) @(posedge clk);
        #1;
        chk("long wait err", {31'd0, err}, 32'd0);
        chk("long wait ack", {28'd0, ack}, 32'd0);
        finish_xfer(2, 4'b0010, 8'hC3);
`endif

        // Reset in WAIT abandons the transfer without ack
        req      = 4'b0100;
        req_data = 32'h00770000;
        sb_q.push_back('{g: 4'b0100, d: 8'h77});
        wait_send();
        req = 4'd0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst gnt", {28'd0, gnt}, 32'd0);
        chk("async rst ack", {28'd0, ack}, 32'd0);
        chk("async rst tx_data", {24'd0, tx_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no ack after rst", {28'd0, ack}, 32'd0);
        end
        run_xfer(4'b1000, 32'hE1000000, 5, 1'b0, 4'b1000, 8'hE1);

        // Vector table from a fresh reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_xfer(tbl[i].r, tbl[i].d, tbl[i].dly, tbl[i].hold, tbl[i].eg, tbl[i].ed);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
